// File: rtl/prod_proc_pkg.sv
// Shared definitions for the multi-channel producer/processor.
// Contents:
//   MODE_PASS/MODE_INC/MODE_INV/MODE_SHL - transform selector encodings
//   apply_mode(x, mode, bypass)          - transform applied to a granted counter value.
//                                          It operates on 32 bits; callers truncate to DATA_W.
package prod_proc_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  // Upper bits of the result are don't-care after truncation. Each mode
  // (+1 wrap, invert, shift-left) therefore gives the correct DATA_W-bit result.
  function automatic logic [31:0] apply_mode(input logic [31:0] x,
                                             input logic [1:0]  mode,
                                             input logic        bypass);
    logic [31:0] r;
    r = x;
    if (bypass) begin
      r = x;
    end else begin
      case (mode)
        MODE_PASS: r = x;
        MODE_INC:  r = x + 32'd1;
        MODE_INV:  r = ~x;
        MODE_SHL:  r = {x[30:0], 1'b0};
        default:   r = x;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_sync_fifo.sv
// Synchronous FIFO with a registered head.
// The head of the queue sits in an output register, so valid_o/rdata_o come
// directly from flops. rdata_o holds its last value when the FIFO drains.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   push_i     - write request, accepted if not full or popping this cycle
//   wdata_i    - write data
//   pop_i      - read request, accepted when valid_o
//   rdata_o    - head data (registered)
//   valid_o    - head valid (registered)
//   full_o     - occupancy == DEPTH
//   empty_o    - occupancy == 0
//   level_o    - occupancy, 0..DEPTH
module pp_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  import prod_proc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          push_ok_s, pop_ok_s;

  assign full_o    = (cnt_q == LW'(DEPTH));
  assign empty_o   = !valid_q;
  assign pop_ok_s  = pop_i && valid_q;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Next-state for pointers, occupancy and the registered head.
  always_comb begin
    wr_d = push_ok_s ? (wr_q + AW'(1)) : wr_q;
    rd_d = pop_ok_s  ? (rd_q + AW'(1)) : rd_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != LW'(0));
    // The new head is the entry being written only when it lands in an
    // otherwise-empty queue (rd_d catches up with the current write slot).
    if (!valid_d) begin
      head_d = head_q;
    end else if (push_ok_s && (rd_d == wr_q)) begin
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push_ok_s) mem_q[wr_q] <= wdata_i;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign rdata_o = head_q;
  assign valid_o = valid_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/multi_chan_prod_proc.sv
// Multi-channel counter traffic source.
// NUM_CH free-running counters are served round-robin. The granted counter
// value is transformed (pass/+1/invert/shl or bypass), tagged with its channel
// id and queued in a DEPTH-entry FIFO. The FIFO drains over valid/ready.
// Backpressure stalls the producers, so no beat is dropped or duplicated.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - global produce enable
//   ch_en      - per-channel enable
//   mode       - transform select; bypass_en - pass raw counter value
//   valid_out, ready_out, data_out, chan_out - output stream
//   fifo_level - FIFO occupancy
module multi_chan_prod_proc #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [1:0]        mode,
  input  logic              bypass_en,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CH_W-1:0]   chan_out,
  output logic [LVL_W-1:0]  fifo_level
);
  import prod_proc_pkg::*;

  logic [DATA_W-1:0] cnt_q [NUM_CH];
  logic [DATA_W-1:0] cnt_d [NUM_CH];
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   win_s;
  logic              found_s, hit_s;
  logic              grant_s, pop_s, full_s, empty_s;
  logic [DATA_W-1:0] tdata_s;

  // Round-robin search: first enabled channel strictly after the last winner.
  always_comb begin
    win_s   = rr_q;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx     = (int'(rr_q) + k) % NUM_CH;
      hit_s   = !found_s && ch_en[idx];
      win_s   = hit_s ? CH_W'(idx) : win_s;
      found_s = found_s | hit_s;
    end
  end

  assign pop_s   = !empty_s && ready_out;
  // A full FIFO can still accept a beat in the cycle its head leaves.
  assign grant_s = en && (|ch_en) && (!full_s || pop_s);
  assign tdata_s = DATA_W'(apply_mode(32'(cnt_q[win_s]), mode, bypass_en));

  // Counter and arbiter next-state: only the winner advances.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = (grant_s && (win_s == CH_W'(i))) ? (cnt_q[i] + DATA_W'(1)) : cnt_q[i];
    end
    rr_d = grant_s ? win_s : rr_q;
  end

  // Counter and round-robin pointer state; ch0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= DATA_W'(i);
      rr_q <= CH_W'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      rr_q <= rr_d;
    end
  end

  pp_sync_fifo #(
    .W     (DATA_W + CH_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant_s),
    .wdata_i ({win_s, tdata_s}),
    .pop_i   (pop_s),
    .rdata_o ({chan_out, data_out}),
    .valid_o (valid_out),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_multi_chan_prod_proc.sv
module tb_multi_chan_prod_proc;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] ch_en;
  logic [1:0] mode;
  logic       bypass_en;
  logic       valid_out;
  logic       ready_out;
  logic [7:0] data_out;
  logic [1:0] chan_out;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  multi_chan_prod_proc #(.DATA_W(8), .NUM_CH(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ch_en      (ch_en),
    .mode       (mode),
    .bypass_en  (bypass_en),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .chan_out   (chan_out),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    en = 1'b0; ch_en = 4'b0000; mode = 2'b00; bypass_en = 1'b0; ready_out = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Bring ch0 counter to value n with ch0 only, then let the FIFO drain.
  task automatic ch0_to(input int n);
    do_reset();
    ch_en = 4'b0001;
    en = 1'b1;
    repeat (n) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk); #1;
  endtask

  // Exactly one grant with the current mode/bypass.
  task automatic one_grant();
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; ch_en = 4'b1111; mode = 2'b00; bypass_en = 1'b0; ready_out = 1'b1;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({valid_out, chan_out, data_out, fifo_level} !== {1'b0, 2'd0, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL reset: got v=%0b c=%0d d=%h l=%0d want 0/0/00/0", valid_out, chan_out, data_out, fifo_level);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    logic [1:0] ec [8];
    logic [7:0] ed [8];
    ec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    ed = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    ch_en = 4'b1111; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid_out, chan_out, data_out, fifo_level} !== {1'b1, ec[i], ed[i], 3'd1}) begin
        errors++;
        $display("FAIL rotation[%0d]: got v=%0b c=%0d d=%h l=%0d want 1/%0d/%h/1", i, valid_out, chan_out, data_out, fifo_level, ec[i], ed[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_inc_wrap();
    logic [7:0] ed [4];
    ed = '{8'hFF, 8'h00, 8'h01, 8'h01};
    do_reset();
    ch_en = 4'b0001; en = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    checks++;
    if (data_out !== 8'hFD) begin
      errors++;
      $display("FAIL preload: got d=%h want fd", data_out);
    end
    en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({valid_out, data_out} !== {1'b0, 8'hFD}) begin
      errors++;
      $display("FAIL empty_hold: got v=%0b d=%h want 0/fd", valid_out, data_out);
    end
    mode = 2'b01; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mode = 2'b00;
      @(posedge clk); #1;
      checks++;
      if ({valid_out, chan_out, data_out} !== {1'b1, 2'd0, ed[i]}) begin
        errors++;
        $display("FAIL inc_wrap[%0d]: got v=%0b c=%0d d=%h want 1/0/%h", i, valid_out, chan_out, data_out, ed[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_transform();
    ch0_to(5);
    mode = 2'b10;
    one_grant();
    checks++;
    if ({valid_out, data_out} !== {1'b1, 8'hFA}) begin
      errors++;
      $display("FAIL invert: got v=%0b d=%h want 1/fa", valid_out, data_out);
    end
    ch0_to(5);
    mode = 2'b10; bypass_en = 1'b1;
    one_grant();
    checks++;
    if ({valid_out, data_out} !== {1'b1, 8'h05}) begin
      errors++;
      $display("FAIL bypass: got v=%0b d=%h want 1/05", valid_out, data_out);
    end
    ch0_to(8'h81);
    mode = 2'b11;
    one_grant();
    checks++;
    if ({valid_out, data_out} !== {1'b1, 8'h02}) begin
      errors++;
      $display("FAIL shl: got v=%0b d=%h want 1/02", valid_out, data_out);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] ec [8];
    logic [7:0] ed [8];
    logic [2:0] el;
    ec = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ed = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02};
    do_reset();
    ch_en = 4'b1111; ready_out = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      el = (i < 4) ? 3'(i) : 3'd4;
      checks++;
      if ({valid_out, chan_out, data_out, fifo_level} !== {1'b1, 2'd0, 8'h00, el}) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%0b c=%0d d=%h l=%0d want 1/0/00/%0d", i, valid_out, chan_out, data_out, fifo_level, el);
      end
    end
    ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid_out, chan_out, data_out, fifo_level} !== {1'b1, ec[i], ed[i], 3'd4}) begin
        errors++;
        $display("FAIL drain[%0d]: got v=%0b c=%0d d=%h l=%0d want 1/%0d/%h/4", i, valid_out, chan_out, data_out, fifo_level, ec[i], ed[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sparse();
    logic [1:0] ec [6];
    logic [7:0] ed [6];
    ec = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2};
    ed = '{8'h01, 8'h03, 8'h02, 8'h04, 8'h00, 8'h02};
    do_reset();
    ch_en = 4'b1010; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid_out, chan_out, data_out} !== {1'b1, ec[i], ed[i]}) begin
        errors++;
        $display("FAIL sparse[%0d]: got v=%0b c=%0d d=%h want 1/%0d/%h", i, valid_out, chan_out, data_out, ec[i], ed[i]);
      end
      if (i == 3) ch_en = 4'b0101;
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ch_en = 4'b1111; ready_out = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_level: got %0d want 3", fifo_level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_out, fifo_level} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL async_reset: got v=%0b l=%0d want 0/0", valid_out, fifo_level);
    end
    ready_out = 1'b1;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid_out, chan_out, data_out, fifo_level} !== {1'b1, 2'd0, 8'h00, 3'd1}) begin
      errors++;
      $display("FAIL post_reset: got v=%0b c=%0d d=%h l=%0d want 1/0/00/1", valid_out, chan_out, data_out, fifo_level);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_inc_wrap();
    test_transform();
    test_backpressure();
    test_sparse();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
